// File: rtl/serial_word_loader_if.sv
// Bundle between the serial bit source, the loader and the downstream register.
// The master side drives the serial stream, clear and the acknowledge; the slave
// side (the loader) returns ready, the assembled word, its valid flag and the count.
interface serial_word_loader_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic             sin;
    logic             sin_valid;
    logic             sin_ready;
    logic             clear;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             word_ack;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output sin,
        output sin_valid,
        input  sin_ready,
        output clear,
        input  word,
        input  word_valid,
        output word_ack,
        input  bit_count
    );

    modport slave (
        input  sin,
        input  sin_valid,
        output sin_ready,
        input  clear,
        output word,
        output word_valid,
        input  word_ack,
        output bit_count
    );
endinterface

// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader. Shifts in one bit per accepted beat until
// WIDTH bits are held, then presents the word with word_valid until the
// downstream register acknowledges it. clear aborts any partial or held word.
// All outputs come straight from registers; ready/valid mirror the state.
module serial_word_loader #(
    parameter int WIDTH     = 32,
    parameter int CNT_W     = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_word_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] word_r;
    logic [WIDTH-1:0] word_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             sin_ready_r;
    logic             sin_ready_s;
    logic             word_valid_r;
    logic             word_valid_s;
    logic             accept_s;

    // Insert one bit at the end selected by MSB_FIRST so that the first bit
    // received ends up in word[WIDTH-1] (MSB first) or word[0] (LSB first).
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w,
                                                  input logic             b);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {w[WIDTH-2:0], b};
        end else begin
            r = {b, w[WIDTH-1:1]};
        end
        return r;
    endfunction

    // Next-state, next-word and next-count decode; clear overrides the handshake.
    always_comb begin
        state_s  = state_r;
        word_s   = word_r;
        count_s  = count_r;
        accept_s = bus.sin_valid & sin_ready_r & ~bus.clear;

        if (bus.clear) begin
            state_s = IDLE;
            word_s  = {WIDTH{1'b0}};
            count_s = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE, SHIFT: begin
                    if (accept_s) begin
                        word_s  = shift_in(word_r, bus.sin);
                        count_s = count_r + ONE_CNT;
                        if (count_r == LAST_CNT) begin
                            state_s = FULL;
                        end else begin
                            state_s = SHIFT;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                FULL: begin
                    // word is left as-is after the ack; it is only meaningful while valid
                    if (bus.word_ack) begin
                        state_s = IDLE;
                        count_s = {CNT_W{1'b0}};
                    end else begin
                        state_s = FULL;
                    end
                end
                default: begin
                    state_s = IDLE;
                    word_s  = {WIDTH{1'b0}};
                    count_s = {CNT_W{1'b0}};
                end
            endcase
        end

        sin_ready_s  = (state_s != FULL);
        word_valid_s = (state_s == FULL);
    end

    // State, data and handshake-flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            word_r       <= {WIDTH{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            sin_ready_r  <= 1'b1;
            word_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            word_r       <= word_s;
            count_r      <= count_s;
            sin_ready_r  <= sin_ready_s;
            word_valid_r <= word_valid_s;
        end
    end

    assign bus.sin_ready  = sin_ready_r;
    assign bus.word       = word_r;
    assign bus.word_valid = word_valid_r;
    assign bus.bit_count  = count_r;
endmodule

// File: tb/tb_serial_word_loader.sv
// Self-checking bench: an MSB-first and an LSB-first loader receive the same
// stream. A bit-list reference model pushes expected words into scoreboards;
// a negedge monitor compares flags every cycle and words when valid rises.
module tb_serial_word_loader;
    logic clk = 1'b0;
    logic reset, sin, sin_valid, clear, word_ack;

    always #5 clk = ~clk;

    serial_word_loader_if #(.WIDTH(32), .CNT_W(6)) if_m ();
    serial_word_loader_if #(.WIDTH(32), .CNT_W(6)) if_l ();

    assign if_m.sin = sin;       assign if_l.sin = sin;
    assign if_m.sin_valid = sin_valid; assign if_l.sin_valid = sin_valid;
    assign if_m.clear = clear;   assign if_l.clear = clear;
    assign if_m.word_ack = word_ack;   assign if_l.word_ack = word_ack;

    serial_word_loader #(.WIDTH(32), .CNT_W(6), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .bus(if_m));
    serial_word_loader #(.WIDTH(32), .CNT_W(6), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .bus(if_l));

    // reference model state
    int          cur_bits[$];
    bit          m_full = 1'b0;
    bit          m_zero = 1'b1;
    int          m_count = 0;
    logic [31:0] exp_m[$];
    logic [31:0] exp_l[$];
    bit          mon_en = 1'b0;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge given the inputs currently driven.
    task automatic model_edge();
        logic [31:0] wm, wl;
        if (reset || clear) begin
            cur_bits.delete();
            m_full = 1'b0;
            m_zero = 1'b1;
        end else if (m_full) begin
            if (word_ack) m_full = 1'b0;
        end else if (sin_valid) begin
            cur_bits.push_back(int'(sin));
            m_zero = 1'b0;
            if (cur_bits.size() == 32) begin
                wm = 32'd0;
                wl = 32'd0;
                for (int i = 0; i < 32; i++) begin
                    wm = (wm << 1) | 32'(cur_bits[i]);
                    wl = wl | (32'(cur_bits[i]) << i);
                end
                exp_m.push_back(wm);
                exp_l.push_back(wl);
                m_full = 1'b1;
                cur_bits.delete();
            end
        end
        m_count = m_full ? 32 : cur_bits.size();
    endtask

    task automatic cycle(input logic r, input logic c, input logic v, input logic b, input logic a);
        reset = r; clear = c; sin_valid = v; sin = b; word_ack = a;
        @(posedge clk);
        model_edge();
        mon_en = 1'b1;
        #1;
    endtask

    // Send nbits of w (MSB of the field first); gaps of 1..maxgap idle cycles between bits.
    task automatic send_bits(input logic [31:0] w, input int nbits, input int maxgap);
        for (int i = nbits - 1; i >= 0; i--) begin
            cycle(1'b0, 1'b0, 1'b1, w[i], 1'($urandom_range(0, 1)));
            if (maxgap > 0 && i > 0) begin
                int g;
                g = $urandom_range(1, maxgap);
                for (int k = 0; k < g; k++)
                    cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
    endtask

    // Hold the full word for n cycles with sin_valid asserted, then one ack edge.
    task automatic hold_and_ack(input int n);
        for (int k = 0; k < n; k++)
            cycle(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: flag checks every cycle, scoreboard pop when the word appears.
    initial begin
        bit          prev_full;
        logic [31:0] held_m, held_l;
        prev_full = 1'b0;
        held_m = 32'd0;
        held_l = 32'd0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("sin_ready_m", 32'(if_m.sin_ready), 32'(!m_full));
                chk("word_valid_m", 32'(if_m.word_valid), 32'(m_full));
                chk("bit_count_m", 32'(if_m.bit_count), 32'(m_count));
                chk("word_valid_l", 32'(if_l.word_valid), 32'(m_full));
                chk("bit_count_l", 32'(if_l.bit_count), 32'(m_count));
                if (m_full && !prev_full) begin
                    if (exp_m.size() == 0 || exp_l.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL scoreboard: word presented with no expected entry at %0t", $time);
                    end else begin
                        held_m = exp_m.pop_front();
                        held_l = exp_l.pop_front();
                    end
                end
                if (m_full) begin
                    chk("word_m", if_m.word, held_m);
                    chk("word_l", if_l.word, held_l);
                end
                if (m_zero) begin
                    chk("word_zero_m", if_m.word, 32'd0);
                    chk("word_zero_l", if_l.word, 32'd0);
                end
                prev_full = m_full;
            end
        end
    end

    initial begin
        // reset
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // T1/T2: back-to-back word, held 10 cycles with sin_valid high, then ack
        send_bits(32'hA5A5F00D, 32, 0);
        hold_and_ack(10);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // T3: random gaps
        send_bits(32'h12345678, 32, 5);
        hold_and_ack(2);
        // T4: 17 bits, clear with a bit presented, then a full word
        send_bits(32'h0001_5A5A, 17, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send_bits(32'hDEADBEEF, 32, 0);
        hold_and_ack(1);
        // T5: reset in FULL and in SHIFT (9 bits)
        send_bits(32'hCAFEF00D, 32, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        send_bits(32'h0000_01FF, 9, 0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // clear while holding a complete word
        send_bits(32'h0F0F0F0F, 32, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // T6: a one followed by 31 zeros
        send_bits(32'h80000000, 32, 0);
        hold_and_ack(0);
        // random words with random gaps and hold times
        for (int n = 0; n < 8; n++) begin
            send_bits($urandom, 32, $urandom_range(0, 3));
            hold_and_ack($urandom_range(0, 4));
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_m.size() + exp_l.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
